// File: rtl/scan_control.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : scan_control                                                    |
// | Purpose  : 8-digit multiplexed display scanner. It double-buffers the      |
// |            digit data, so new data reaches the display only at a frame     |
// |            boundary.                                                       |
// | Option   : LEADING_ZERO_BLANK_EN turns off the anodes of leading-zero slots.|
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module scan_control #(
  parameter int unsigned REFRESH_DIV = 100000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        disp_en,
  input  logic        wr_en,
  input  logic [31:0] wr_data,
  output logic [2:0]  refreshcounter,
  output logic [3:0]  one_digit,
  output logic [7:0]  an,
  output logic        pending,
  output logic        frame_done
);

  localparam int unsigned          C_PW   = $clog2(REFRESH_DIV);
  localparam logic [C_PW-1:0]      C_LAST = C_PW'(REFRESH_DIV - 1);

  logic [C_PW-1:0] prescaler_q, prescaler_d;
  logic [2:0]      slot_q, slot_d;
  logic [31:0]     shadow_q, shadow_d;
  logic [31:0]     active_q, active_d;
  logic            pending_q, pending_d;
  logic            frame_done_q, frame_done_d;

  logic            w_tick;
  logic            w_boundary;
  logic [7:0]      w_blank;

  assign w_tick     = (prescaler_q == C_LAST);
  assign w_boundary = w_tick && (slot_q == 3'd7);

  always_comb begin
    prescaler_d  = w_tick ? '0 : prescaler_q + C_PW'(1);
    slot_d       = w_tick ? slot_q + 3'd1 : slot_q;
    frame_done_d = w_boundary;
    shadow_d     = wr_en ? wr_data : shadow_q;
    active_d     = active_q;
    pending_d    = pending_q;
    // A write on the boundary bypasses the shadow so it is never lost a frame.
    if (w_boundary && wr_en) begin
      active_d  = wr_data;
      pending_d = 1'b0;
    end else if (w_boundary && pending_q) begin
      active_d  = shadow_q;
      pending_d = 1'b0;
    end else if (wr_en) begin
      pending_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prescaler_q  <= '0;
      slot_q       <= 3'd0;
      shadow_q     <= 32'd0;
      active_q     <= 32'd0;
      pending_q    <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      prescaler_q  <= prescaler_d;
      slot_q       <= slot_d;
      shadow_q     <= shadow_d;
      active_q     <= active_d;
      pending_q    <= pending_d;
      frame_done_q <= frame_done_d;
    end
  end

`ifdef LEADING_ZERO_BLANK_EN
  // Slot i is dark when it and every slot above it hold zero; slot 0 always shows.
  for (genvar gi = 0; gi < 8; gi++) begin : g_blank
    if (gi == 0) begin : g_digit0
      assign w_blank[gi] = 1'b0;
    end else begin : g_upper
      assign w_blank[gi] = (active_q[31:4*gi] == '0);
    end
  end
`else
  assign w_blank = 8'h00;
`endif

  always_comb begin
    an = 8'hFF;
    if (disp_en && !w_blank[slot_q]) begin
      an[slot_q] = 1'b0;
    end
  end

  assign refreshcounter = slot_q;
  assign one_digit      = active_q[{slot_q, 2'b00} +: 4];
  assign pending        = pending_q;
  assign frame_done     = frame_done_q;

endmodule
`default_nettype wire

// File: doc/scan_control.md
SCAN_CONTROL -- requirements
Module: scan_control

Interface
REQ-001 SHALL have parameter REFRESH_DIV, default 100000, clk cycles per digit slot (legal range 2..2^20).
REQ-002 SHALL have port clk  input  1  single system clock; all state on rising edge.
REQ-003 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-004 SHALL have port disp_en  input  1  1 = anodes driven; 0 = all anodes off, scanning continues.
REQ-005 SHALL have port wr_en  input  1  single-cycle strobe loading wr_data into the shadow buffer.
REQ-006 SHALL have port wr_data  input  32  eight BCD nibbles; [3:0] = digit 0 (rightmost), [31:28] = digit 7.
REQ-007 SHALL have port refreshcounter  output  3  current digit slot index, registered.
REQ-008 SHALL have port one_digit  output  4  active-buffer nibble for the current slot.
REQ-009 SHALL have port an  output  8  anode enables, active-low, one-hot-low at most.
REQ-010 SHALL have port pending  output  1  shadow holds data not yet transferred to active.
REQ-011 SHALL have port frame_done  output  1  one-cycle pulse on each frame boundary.

Function
REQ-012 SHALL run a prescaler counting 0..REFRESH_DIV-1 and wrapping to 0; tick = (prescaler == REFRESH_DIV-1).
REQ-013 SHALL increment refreshcounter on each tick, modulo 8 (7 -> 0), and hold it otherwise.
REQ-014 SHALL define the frame boundary as a tick while refreshcounter == 7.
REQ-015 SHALL assert frame_done for exactly the cycle following the frame-boundary edge (registered, coincident with refreshcounter becoming 0).
REQ-016 SHALL drive one_digit = active[4*refreshcounter +: 4] combinationally from registered state.
REQ-017 SHALL drive an[i] = 0 only when i == refreshcounter and disp_en == 1 (and the slot is not blanked, see REQ-026); otherwise an[i] = 1.
REQ-018 SHALL write wr_data into shadow and set pending on wr_en; a later wr_en before transfer overwrites shadow (last write wins).
REQ-019 SHALL, at a frame boundary with pending == 1, copy shadow to active and clear pending in the same edge.
REQ-020 SHALL, on simultaneous wr_en and frame boundary, load wr_data into both shadow and active and leave pending = 0 (bypass).
REQ-021 SHALL leave active unchanged at a frame boundary with pending == 0.
REQ-022 SHALL never change active mid-frame; the display updates only at slot 0.
REQ-023 SHALL pass nibble values 10..15 through unmodified (no range check).

Reset
REQ-024 SHALL, while rst_n == 0 (asynchronously), force prescaler = 0, refreshcounter = 0, shadow = 0, active = 0, pending = 0, frame_done = 0; an = 8'hFE if disp_en == 1, else 8'hFF.
REQ-025 SHALL, on reset release, restart scanning from slot 0 with a full REFRESH_DIV-cycle first slot; reset mid-frame discards pending data.

Configuration
REQ-026 SHALL, with LEADING_ZERO_BLANK_EN defined, hold an[i] = 1 for slot i whenever active nibbles i..7 are all zero and i != 0; digit 0 is never blanked; refreshcounter and one_digit are unaffected.
REQ-027 SHALL, without LEADING_ZERO_BLANK_EN, drive all eight slots per REQ-017 with no blanking logic present.

Verification (REFRESH_DIV = 4)
REQ-028 SHALL cover reset/scan: release reset -> refreshcounter steps 0,1,..,7,0 every 4 clk; an walks FE,FD,..,7F; frame_done pulses once per 32 clk.
REQ-029 SHALL cover mid-frame load: wr_en with 32'h12345678 at slot 3 -> pending = 1, one_digit unchanged until slot 0; at slot 0 one_digit = 8, pending = 0.
REQ-030 SHALL cover overwrite: two wr_en (32'h11111111 then 32'h22222222) within one frame -> next frame shows all 2s.
REQ-031 SHALL cover collision: wr_en 32'h0000ABCD on the frame-boundary cycle -> next cycle active = 32'h0000ABCD, pending = 0.
REQ-032 SHALL cover blanking: with the macro defined, active = 32'h00000405 -> an low only in slots 0..2; active = 0 -> only slot 0 lit; without the macro, all slots lit.
REQ-033 SHALL cover disp_en and async reset: disp_en = 0 -> an = FF while refreshcounter keeps stepping; rst_n low at slot 5 with pending = 1 -> immediate refreshcounter = 0, pending = 0, active = 0.
